// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: FIPS 180-4 byte-stream padder emitting 512-bit blocks tagged first/last.
// Define SHA256_PAD_EMPTY_EN to add in_empty for zero-length messages.
module sha256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
`ifdef SHA256_PAD_EMPTY_EN
    input  logic         in_empty,
`endif
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         blk_ready
);
    localparam logic [1:0] FILL = 2'd0, PAD = 2'd1, LENBLK = 2'd2, EMIT = 2'd3;
    logic [1:0]       state, nxt_state;
    logic [6:0]       idx;
    logic [LEN_W-1:0] cnt;
    logic             first_flag, bnd;
    logic [63:0][7:0] stage, pad_blk;
    logic [63:0]      bit_len;
    logic             take, empty_go;
    assign in_ready  = state == FILL;
    assign blk_valid = state == EMIT;
    assign take      = in_valid && in_ready;
    assign bit_len   = 64'({cnt, 3'b000});
`ifdef SHA256_PAD_EMPTY_EN
    assign empty_go  = in_ready && in_empty && idx == 7'd0 && cnt == '0;
`else
    assign empty_go  = 1'b0;
`endif
    // stage[63] is byte 0; bytes past the message are forced to zero since stage may hold stale data
    for (genvar b = 0; b < 64; b++) begin : g_pad
        if (b >= 56) begin : g_len
            assign pad_blk[63-b] = idx > 7'(b) ? stage[63-b] : idx == 7'(b) ? 8'h80 :
                                   idx <= 7'd55 ? bit_len[8*(63-b) +: 8] : 8'h00;
        end else begin : g_dat
            assign pad_blk[63-b] = idx > 7'(b) ? stage[63-b] : idx == 7'(b) ? 8'h80 : 8'h00;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            nxt_state  <= FILL;
            idx        <= '0;
            cnt        <= '0;
            first_flag <= 1'b1;
            bnd        <= 1'b0;
            stage      <= '0;
            blk_data   <= '0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (empty_go) begin
                        state <= PAD;
                    end else if (take) begin
                        stage[6'd63 - idx[5:0]] <= in_data;
                        cnt <= cnt + 1'b1;
                        if (in_last) begin
                            idx   <= idx + 7'd1;
                            state <= PAD;
                        end else if (idx == 7'd63) begin
                            idx       <= '0;
                            blk_data  <= {stage[63:1], in_data};
                            blk_first <= first_flag;
                            blk_last  <= 1'b0;
                            nxt_state <= FILL;
                            state     <= EMIT;
                        end else begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                PAD: begin
                    blk_data  <= pad_blk;
                    blk_first <= first_flag;
                    blk_last  <= idx <= 7'd55;
                    nxt_state <= idx <= 7'd55 ? FILL : LENBLK;
                    bnd       <= idx == 7'd64;
                    state     <= EMIT;
                end
                LENBLK: begin
                    blk_data  <= {bnd ? 8'h80 : 8'h00, 440'd0, bit_len};
                    blk_first <= first_flag;
                    blk_last  <= 1'b1;
                    nxt_state <= FILL;
                    state     <= EMIT;
                end
                default: begin
                    if (blk_ready) begin
                        state      <= nxt_state;
                        first_flag <= blk_last;
                        if (blk_last) begin
                            cnt   <= '0;
                            idx   <= '0;
                            stage <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Byte-stream front end for the simplified SHA-256 core.
- Accepts an arbitrary-length message one byte at a time over a valid/ready interface.
- Applies FIPS 180-4 padding: a 0x80 byte, then zeros, then the 64-bit big-endian bit length.
- Emits the resulting 512-bit blocks, each tagged first/last, to the core over a valid/ready handshake.

Parameters:
- LEN_W, 32: width of the internal message byte counter. Bit length = counter concatenated with 3'b000, zero-extended to 64 bits. Maximum message is 2^LEN_W - 1 bytes; the counter wraps beyond that.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  message byte
- in_valid  in  1  in_data is valid
- in_last  in  1  qualifies in_data as the final message byte
- in_ready  out  1  padder accepts a byte this cycle
- blk_data  out  512  padded block; byte 0 in [511:504], byte 63 in [7:0]
- blk_valid  out  1  blk_data is valid
- blk_first  out  1  block is the first of its message (core loads initial H)
- blk_last  out  1  block is the final block of its message (core result is final)
- blk_ready  in  1  core accepts the block

Behaviour:
- Reset (asynchronous, active-high) returns to FILL with:
  - idx (block byte index, 0..63) = 0
  - byte count = 0
  - first_flag = 1
  - blk_data = 0
  - blk_valid = 0, blk_first = 0, blk_last = 0
  - in_ready = 1 once reset deasserts
- Reset mid-message discards any partial block and any pending output without emitting it.
- A byte transfer occurs on a clock edge where in_valid && in_ready. A block transfer occurs on an edge where blk_valid && blk_ready.
- in_ready = 1 only in FILL. blk_valid = 1 only in EMIT.
- States:
  - FILL: each accepted byte is written to position idx; idx increments and the byte count increments.
    - Byte accepted with in_last=0 and idx=63 -> EMIT, with blk_last=0 and next state FILL.
    - Byte accepted with in_last=1 -> PAD.
  - PAD: exactly one cycle. Let n = number of bytes held (0..64).
    - n=64: block emitted unchanged, blk_last=0, next state LENBLK.
    - n<=55: byte n=0x80, bytes n+1..55 = 0, bytes 56..63 = bit length; blk_last=1; next state FILL.
    - 56<=n<=63: byte n=0x80, bytes n+1..63 = 0, blk_last=0, next state LENBLK.
  - LENBLK: one cycle. Builds the final block and sets blk_last=1, next state FILL.
    - Byte 0 = 0x80 if the message ended exactly on a 64-byte boundary, otherwise 0.
    - Remaining bytes 1..55 = 0; bytes 56..63 = bit length.
  - EMIT: blk_data, blk_first and blk_last are held stable while blk_ready=0.
    - On transfer, go to the next state recorded when EMIT was entered.
    - first_flag clears after the transfer.
    - If blk_last was 1: byte count, idx and the staging buffer clear, and first_flag sets.
- blk_first = first_flag at the moment the block is formed.
- Latency from the edge accepting in_last to blk_valid high: 2 edges (PAD, then EMIT).
- A full non-last block goes valid on the edge after the 64th byte is accepted.
- A 1-byte message goes FILL -> PAD -> EMIT.
- No bytes are accepted during PAD, LENBLK or EMIT; the input stalls via in_ready=0.

Optional Feature:
- Macro: SHA256_PAD_EMPTY_EN.
- Defined: adds input port in_empty (1 bit), sampled only in FILL with idx=0 and byte count=0.
  - in_empty=1 when in_ready is high -> PAD with n=0.
  - Produces a single block: 0x80 followed by zeros, length 0, blk_first=1, blk_last=1.
  - in_empty is ignored at any other time.
- Not defined: the port is absent; messages are at least 1 byte and a zero-length message is unrepresentable.

Test Plan:
- Send ASCII "1234567890" (10 bytes, last on 0x30), blk_ready=1 -> one block = {31 32 33 34 35 36 37 38 39 30 80, 52 zero bytes, 50 hex}, with first=1 and last=1.
- Send 55 bytes alternating "ab" (ending 'a') -> single block; byte 55=0x80; bytes 56..63 = 00..01 B8; last=1.
- Send 56 bytes of 'a' -> block 1 has byte 56=0x80, first=1, last=0; block 2 is zeros with 00..01 C0 in bytes 56..63, first=0, last=1.
- Send 64 bytes -> block 1 holds the data, last=0; block 2 = 0x80, zeros, 00..02 00 in bytes 56..63, last=1.
- Hold blk_ready=0 for 10 cycles during EMIT -> blk_data and flags stay stable and in_ready stays 0; on release, one transfer, then in_ready returns to 1.
- Assert reset after 30 bytes, then send "1234567890" -> no block is emitted for the aborted message; the next block matches the first scenario exactly, with first=1.
